// File: rtl/div_unit.sv
// Multi-cycle restoring divider (one quotient bit per cycle) for DIV/DIVU; result is {remainder, quotient}.
// Define DIV_EARLY_OUT_EN to finish at once when |dividend| < |divisor|.
module div_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  // Handshake: start_i is level-held by the requester and only sampled in IDLE;
  // ready_o is high exactly while result_o is valid and drops the cycle after start_i falls.
  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               ready_q, ready_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0]   op1_abs, op2_abs;
  logic [WIDTH:0]     trial;

  assign op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    ready_d   = 1'b0;
    result_d  = '0;
    // Partial remainder stays below the divisor, so WIDTH+1 bits hold the shifted value.
    trial     = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};

    case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = BYZERO;
`ifdef DIV_EARLY_OUT_EN
          end else if (op1_abs < op2_abs) begin
            state_d = END;
            rem_d   = opdata1_i;
            quo_d   = '0;
`endif
          end else begin
            state_d   = ON;
            rem_d     = '0;
            quo_d     = op1_abs;
            dvs_d     = op2_abs;
            cnt_d     = '0;
            neg_quo_d = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem_d = signed_div_i & opdata1_i[WIDTH-1];
          end
        end
      end
      BYZERO: begin
        state_d = END;
        rem_d   = '0;
        quo_d   = '0;
      end
      ON: begin
        if (annul_i) begin
          state_d = IDLE;
        end else if (cnt_q != CNT_W'(WIDTH)) begin
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          quo_d   = neg_quo_q ? -quo_q : quo_q;
          rem_d   = neg_rem_q ? -rem_q : rem_q;
          state_d = END;
        end
      end
      END: begin
        if (start_i) begin
          ready_d  = 1'b1;
          result_d = {rem_q, quo_q};
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
    end
  end

  assign ready_o  = ready_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: 32-bit instance for the main vectors, 8-bit instance for the narrow case.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div, start, annul;
  logic [31:0] op1, op2;
  logic [63:0] result;
  logic        ready;

  logic        s8_signed, s8_start, s8_annul;
  logic [7:0]  s8_op1, s8_op2;
  logic [15:0] s8_result;
  logic        s8_ready;

  logic [63:0] exp_q[$];
  int          n_checks = 0;
  int          n_err    = 0;

  div_unit #(.WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div), .opdata1_i(op1), .opdata2_i(op2),
    .start_i(start), .annul_i(annul), .result_o(result), .ready_o(ready)
  );

  div_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .signed_div_i(s8_signed), .opdata1_i(s8_op1), .opdata2_i(s8_op2),
    .start_i(s8_start), .annul_i(s8_annul), .result_o(s8_result), .ready_o(s8_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full transaction: hold start until ready, check latency/result, hold, release.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input int exp_lat);
    int          lat;
    logic [63:0] want;
    @(negedge clk);
    signed_div = sgn; op1 = a; op2 = b; start = 1'b1;
    exp_q.push_back({er, eq});
    @(posedge clk);
    #1;
    op1 = $urandom; op2 = $urandom; signed_div = ~sgn;
    lat = 0;
    while (!ready && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_ready"}, 64'(ready), 64'd1);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    want = exp_q.pop_front();
    check({tag, "_res"}, result, want);
    @(posedge clk);
    #1;
    check({tag, "_hold_rdy"}, 64'(ready), 64'd1);
    check({tag, "_hold_res"}, result, want);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_drop_rdy"}, 64'(ready), 64'd0);
    check({tag, "_drop_res"}, result, 64'd0);
  endtask

  task automatic watch_idle(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (ready) seen = 1'b1;
    end
    check({tag, "_no_ready"}, 64'(seen), 64'd0);
    check({tag, "_res_zero"}, result, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat8;
    rst = 1'b1; signed_div = 1'b0; start = 1'b0; annul = 1'b0; op1 = '0; op2 = '0;
    s8_signed = 1'b0; s8_start = 1'b0; s8_annul = 1'b0; s8_op1 = '0; s8_op2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_div("u_100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          34);
    do_div("s_m7_2",    1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   34);
    do_div("s_7_m2",    1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          34);
    do_div("div_zero",  1'b0, 32'd123,        32'd0,          32'd0,          32'd0,          2);
    do_div("u_max_1",   1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          34);
    do_div("s_min_m1",  1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          34);
    do_div("u_msb_3",   1'b0, 32'h80000000,   32'd3,          32'h2AAAAAAA,   32'd2,          34);
`ifdef DIV_EARLY_OUT_EN
    do_div("u_5_9",     1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1);
    do_div("s_m5_9",    1'b1, 32'hFFFFFFFB,   32'd9,          32'd0,          32'hFFFFFFFB,   1);
`else
    do_div("u_5_9",     1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          34);
    do_div("s_m5_9",    1'b1, 32'hFFFFFFFB,   32'd9,          32'd0,          32'hFFFFFFFB,   34);
`endif

    // Annul part-way through a divide.
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    @(posedge clk);
    repeat (9) @(negedge clk);
    annul = 1'b1; start = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    watch_idle("annul", 40);
    do_div("after_annul", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 34);

    // Reset part-way through a divide.
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd50; op2 = 32'd5; start = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_ready", 64'(ready), 64'd0);
    check("rst_mid_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    watch_idle("rst_mid", 40);
    do_div("after_rst", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 34);

    // Narrow instance: 200 / 13 = 15 r 5.
    @(negedge clk);
    s8_signed = 1'b0; s8_op1 = 8'd200; s8_op2 = 8'd13; s8_start = 1'b1;
    @(posedge clk);
    #1;
    lat8 = 0;
    while (!s8_ready && lat8 < 100) begin
      @(posedge clk);
      #1;
      lat8++;
    end
    check("w8_lat", 64'(lat8), 64'd10);
    check("w8_res", 64'(s8_result), 64'h050F);
    @(negedge clk);
    s8_start = 1'b0;
    @(posedge clk);
    #1;
    check("w8_drop_rdy", 64'(s8_ready), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
